// File: rtl/bx_sequencer.sv
// bx_sequencer: watches the link for start/stop sentinels, generates BX timing
// and forwards ordinary stub words one cycle later, aligned with that timing.
module bx_sequencer #(
    parameter int INPUT_SIZE = 36,
    parameter int CLKS_PER_BX = 150,
    parameter logic [INPUT_SIZE-1:0] START_WORD = 36'hFFFFFFFFF,
    parameter logic [INPUT_SIZE-1:0] STOP_WORD = 36'hFFFFFFFFE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INPUT_SIZE-1:0] link_in,
    input  logic                  link_valid,
    output logic                  en_proc,
    output logic [2:0]            BX,
    output logic                  first_clk,
    output logic                  not_first_clk,
    output logic [INPUT_SIZE-1:0] stub_out,
    output logic                  stub_valid,
    output logic                  run_active
);
    localparam int CW = $clog2(CLKS_PER_BX);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BX - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] clk_cnt;
    logic is_start, is_stop, is_word, last;
    assign is_start = link_valid && link_in == START_WORD;
    assign is_stop = link_valid && link_in == STOP_WORD;
    assign is_word = link_valid && !is_start && !is_stop;
    assign last = clk_cnt == LAST;
    assign not_first_clk = en_proc & ~first_clk;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            en_proc <= 1'b0;
            BX <= 3'b111;
            first_clk <= 1'b0;
            stub_out <= '0;
            stub_valid <= 1'b0;
            run_active <= 1'b0;
            clk_cnt <= '0;
        end else if (state == IDLE) begin
            stub_valid <= 1'b0;
            if (is_start) begin
                state <= RUN;
                en_proc <= 1'b1;
                BX <= 3'd0;
                clk_cnt <= '0;
                first_clk <= 1'b1;
                run_active <= 1'b1;
            end
        end else begin
            stub_valid <= is_word;
            if (is_word) stub_out <= link_in;
            // the run only ever ends on a BX boundary
            if (last && (state == DRAIN || is_stop)) begin
                state <= IDLE;
                en_proc <= 1'b0;
                BX <= 3'b111;
                first_clk <= 1'b0;
                clk_cnt <= '0;
                run_active <= 1'b0;
            end else begin
                clk_cnt <= last ? '0 : clk_cnt + 1'b1;
                first_clk <= last;
                if (last) BX <= BX + 3'd1;
                if (state == RUN && is_stop) state <= DRAIN;
            end
        end
    end
endmodule
